dmem_pipe: RTL and testbench
============================

DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 12: byte-address width; memory holds 2**(WIDTH-2) 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2: read latency in cycles, legal 1..8.
REQ-003 SHALL have parameter QDEPTH, default 4: max outstanding reads (power of two, 2..16).
REQ-004 SHALL have parameter TAGW, default 4: request tag width.
REQ-005 SHALL have one clock and a synchronous, active-high reset: port list starts with i_clk input 1 (rising-edge clock), then i_rst input 1 (synchronous, active-high reset).
REQ-006 i_req_valid input 1 -- request present.
REQ-007 o_req_ready output 1 -- request accepted this cycle if also valid.
REQ-008 i_we input 1 -- 1 write, 0 read.
REQ-009 i_addr input WIDTH -- byte address; bits [1:0] ignored.
REQ-010 i_wdata input 32 -- write data.
REQ-011 i_be input 4 -- write byte enables; bit k gates byte k.
REQ-012 i_tag input TAGW -- read tag, returned with data.
REQ-013 i_flush input 1 -- discard all in-flight and queued reads.
REQ-014 o_rsp_valid output 1 -- response available.
REQ-015 i_rsp_ready input 1 -- consumer takes response.
REQ-016 o_rsp_data output 32 -- read data.
REQ-017 o_rsp_tag output TAGW -- tag of returned read.

Function
REQ-018 Accept = i_req_valid & o_req_ready, sampled at rising edge of i_clk.
REQ-019 Accepted write SHALL update word i_addr[WIDTH-1:2] at that edge, bytes per i_be; no response generated; i_be=0 leaves memory unchanged.
REQ-020 Accepted read SHALL sample memory at acceptance edge, so a read accepted the cycle after a write to the same word returns the new data.
REQ-021 Read data and tag SHALL traverse a LATENCY-stage pipeline, then enter a QDEPTH-entry response FIFO; read accepted at edge N is visible on o_rsp_* after edge N+LATENCY-1 (o_rsp_valid high in cycle N+LATENCY) when FIFO empty.
REQ-022 Responses SHALL return in acceptance order; FIFO entry popped at edge where o_rsp_valid & i_rsp_ready.
REQ-023 Outstanding counter OUT (pipeline + FIFO reads) SHALL increment on read accept, decrement on pop, hold on both or neither; range 0..QDEPTH.
REQ-024 o_req_ready SHALL equal (OUT < QDEPTH) & ~i_flush; writes SHALL also obey ready.
REQ-025 Full: OUT==QDEPTH -> o_req_ready=0; pop in same cycle does not raise ready until next cycle (ready is combinational from registered OUT).
REQ-026 FIFO read/write pointers SHALL wrap modulo QDEPTH; empty/full distinguished by an extra pointer bit or count.
REQ-027 o_rsp_data/o_rsp_tag SHALL show FIFO head; value undefined-but-stable (hold last) when o_rsp_valid=0.
REQ-028 i_flush=1 at an edge SHALL clear all pipeline valid bits, empty FIFO, set OUT=0; no pop counted, no request accepted that cycle; memory untouched.
REQ-029 i_flush and write in same cycle: write SHALL NOT occur (ready low).
REQ-030 o_rsp_valid held with i_rsp_ready=0 SHALL keep data/tag stable until popped.

Reset
REQ-031 i_rst=1 at an edge SHALL clear pipeline valids, FIFO pointers, OUT; takes priority over i_flush and requests.
REQ-032 After reset: o_rsp_valid=0, o_req_ready=1 (when i_flush=0), o_rsp_data=0, o_rsp_tag=0.
REQ-033 Memory array SHALL NOT be reset; reads issued mid-flight when reset asserts SHALL be dropped.

Verification
REQ-034 Write 0xDEADBEEF to 0x010 be=1111, next cycle read 0x010 tag=3 -> LATENCY=2: o_rsp_valid high 2 cycles after accept, data 0xDEADBEEF, tag 3.
REQ-035 Write 0x11223344 be=1111 then 0xAABBCCDD be=0101 to 0x020, read -> 0x11BB33DD.
REQ-036 i_rsp_ready=0, issue 5 reads back-to-back (QDEPTH=4) -> 4 accepted, o_req_ready=0 from 5th cycle; raise i_rsp_ready -> tags return in order, ready rises cycle after first pop.
REQ-037 Two reads in flight + one in FIFO, pulse i_flush -> o_rsp_valid=0 next cycle, OUT=0, no stale responses for 10 cycles.
REQ-038 Assert i_rst with 3 reads outstanding -> o_rsp_valid=0, o_req_ready=1 after edge; previously written memory data still readable.
REQ-039 Random read/write/flush/backpressure for 10000 cycles vs reference model, LATENCY 1 and 8 -> zero mismatches, OUT never exceeds QDEPTH.

Source files
------------

// File: rtl/dmem_pipe.sv
// dmem_pipe: word-organised data memory with byte-enable writes and
// tagged, in-order read responses. A read samples the memory at the edge
// where it is accepted. Its data then moves through a fixed-length pipeline
// into a small response FIFO. An outstanding-read counter throttles the
// request side so that the FIFO can never overflow. Because of that the
// pipeline never needs to stall.
module dmem_pipe #(
  parameter int WIDTH   = 12,  // byte-address width
  parameter int LATENCY = 2,   // read latency, 1..8
  parameter int QDEPTH  = 4,   // max outstanding reads, power of two 2..16
  parameter int TAGW    = 4    // request tag width
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_we,
  input  logic [WIDTH-1:0]  i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_be,
  input  logic [TAGW-1:0]   i_tag,
  input  logic              i_flush,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_data,
  output logic [TAGW-1:0]   o_rsp_tag
);

  localparam int DEPTH = 2 ** (WIDTH - 2);
  localparam int PW    = $clog2(QDEPTH);
  localparam int OW    = $clog2(QDEPTH + 1);

  // Storage: the data memory itself plus the response FIFO.
  logic [31:0]      r_mem       [DEPTH];
  logic [31:0]      r_fifo_data [QDEPTH];
  logic [TAGW-1:0]  r_fifo_tag  [QDEPTH];

  // FIFO pointers carry one extra wrap bit, so that full and empty can be
  // told apart.
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;

  // Reads in flight anywhere between acceptance and pop.
  logic [OW-1:0]    r_out;

  // Last head value shown, kept on the outputs while the FIFO is empty.
  logic [31:0]      r_hold_data;
  logic [TAGW-1:0]  r_hold_tag;

  logic [WIDTH-3:0] w_word;
  logic             w_unused_addr_lsb;
  logic             w_acc;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_head_data;
  logic [TAGW-1:0]  w_head_tag;

  // Read pipeline chain. Element k is the input of stage k. The last element
  // is what gets written into the FIFO.
  logic             w_cv [LATENCY];
  logic [31:0]      w_cd [LATENCY];
  logic [TAGW-1:0]  w_ct [LATENCY];

  assign w_word            = i_addr[WIDTH-1:2];
  assign w_unused_addr_lsb = ^i_addr[1:0];

  // Ready depends only on registered state and on flush. A pop therefore
  // frees a slot only from the following cycle onward.
  assign o_req_ready = (r_out < OW'(QDEPTH)) & ~i_flush;

  // Reset overrides everything, so nothing is accepted while it is applied.
  assign w_acc    = i_req_valid & o_req_ready & ~i_rst;
  assign w_wr_acc = w_acc & i_we;
  assign w_rd_acc = w_acc & ~i_we;

  // Byte-lane writes. The memory is never reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      for (int k = 0; k < 4; k++) begin
        if (i_be[k]) begin
          r_mem[w_word][k*8 +: 8] <= i_wdata[k*8 +: 8];
        end
      end
    end
  end

  // The head of the chain is the memory read port. The first register that
  // takes this value (a stage register, or the FIFO entry when LATENCY is 1)
  // acts as the registered read of the RAM.
  assign w_cv[0] = w_rd_acc;
  assign w_cd[0] = r_mem[w_word];
  assign w_ct[0] = i_tag;

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY - 1; gi++) begin : g_stage
      logic             r_v;
      logic [31:0]      r_d;
      logic [TAGW-1:0]  r_t;

      // Advance one pipeline stage. Reset and flush drop everything in flight.
      always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
          r_v <= 1'b0;
        end else begin
          r_v <= w_cv[gi];
        end
        if (w_cv[gi]) begin
          r_d <= w_cd[gi];
          r_t <= w_ct[gi];
        end
      end

      assign w_cv[gi+1] = r_v;
      assign w_cd[gi+1] = r_d;
      assign w_ct[gi+1] = r_t;
    end
  endgenerate

  assign w_empty     = (r_wptr == r_rptr);
  assign o_rsp_valid = ~w_empty;
  assign w_push      = w_cv[LATENCY-1] & ~i_flush & ~i_rst;
  assign w_pop       = o_rsp_valid & i_rsp_ready & ~i_flush & ~i_rst;
  assign w_head_data = r_fifo_data[r_rptr[PW-1:0]];
  assign w_head_tag  = r_fifo_tag[r_rptr[PW-1:0]];

  // Write the FIFO entry. The outstanding limit guarantees a free slot here.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr[PW-1:0]] <= w_cd[LATENCY-1];
      r_fifo_tag[r_wptr[PW-1:0]]  <= w_ct[LATENCY-1];
    end
  end

  // FIFO pointer update. Flush and reset empty the queue in one edge.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (PW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (PW+1)'(1);
      end
    end
  end

  // Outstanding-read count: +1 on read accept, -1 on pop, hold when both
  // or neither occur.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_out <= '0;
    end else begin
      case ({w_rd_acc, w_pop})
        2'b10:   r_out <= r_out + OW'(1);
        2'b01:   r_out <= r_out - OW'(1);
        default: r_out <= r_out;
      endcase
    end
  end

  // Track the displayed head, so the outputs hold steady once the FIFO drains.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_data <= '0;
      r_hold_tag  <= '0;
    end else if (!w_empty) begin
      r_hold_data <= w_head_data;
      r_hold_tag  <= w_head_tag;
    end
  end

  assign o_rsp_data = w_empty ? r_hold_data : w_head_data;
  assign o_rsp_tag  = w_empty ? r_hold_tag  : w_head_tag;

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: drives three dmem_pipe instances (LATENCY 1, 2 and 8) with the
// same inputs and compares every output, on every cycle, against a
// transaction-level model. Directed sequences use the LATENCY=2 instance
// for explicit timing checks.
module tb_dmem_pipe;
  localparam int AW = 8;
  localparam int QD = 4;
  localparam int TW = 4;
  localparam int ND = 3;
  localparam int NW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           req_valid;
  logic           we;
  logic [AW-1:0]  addr;
  logic [31:0]    wdata;
  logic [3:0]     be;
  logic [TW-1:0]  tag;
  logic           flush;
  logic           rsp_ready;

  logic           rdy   [ND];
  logic           vld   [ND];
  logic [31:0]    rdata [ND];
  logic [TW-1:0]  rtag  [ND];

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 2 : 8);
      dmem_pipe #(.WIDTH(AW), .LATENCY(LAT), .QDEPTH(QD), .TAGW(TW)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (rdy[gi]),
        .i_we        (we),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .i_be        (be),
        .i_tag       (tag),
        .i_flush     (flush),
        .o_rsp_valid (vld[gi]),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rdata[gi]),
        .o_rsp_tag   (rtag[gi])
      );
    end
  endgenerate

  // Reference model. Each instance keeps its own memory image and an ordered
  // list of outstanding reads. Each list entry holds the edge after which
  // the read becomes visible.
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            chk_en   = 1'b0;
  int            ecount   = 0;
  logic [31:0]   mmem  [ND][NW];
  int            mcnt  [ND];
  logic [31:0]   mdata [ND][QD];
  logic [TW-1:0] mtag  [ND][QD];
  int            mdue  [ND][QD];
  logic [31:0]   mlast_d [ND];
  logic [TW-1:0] mlast_t [ND];

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 8);
  endfunction

  function automatic bit visible(int d);
    return (mcnt[d] > 0) && (mdue[d][0] <= ecount);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Apply this cycle's inputs to the model, as the coming rising edge will.
  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      bit ev;
      bit er;
      ev = visible(d);
      er = (mcnt[d] < QD) && !flush;
      if (rst) begin
        mcnt[d]    = 0;
        mlast_d[d] = '0;
        mlast_t[d] = '0;
      end else if (flush) begin
        mcnt[d] = 0;
      end else begin
        if (ev && rsp_ready) begin
          for (int k = 0; k < QD - 1; k++) begin
            mdata[d][k] = mdata[d][k+1];
            mtag[d][k]  = mtag[d][k+1];
            mdue[d][k]  = mdue[d][k+1];
          end
          mcnt[d]--;
        end
        if (req_valid && er) begin
          if (we) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) mmem[d][addr[7:2]][b*8 +: 8] = wdata[b*8 +: 8];
          end else begin
            mdata[d][mcnt[d]] = mmem[d][addr[7:2]];
            mtag[d][mcnt[d]]  = tag;
            mdue[d][mcnt[d]]  = ecount + lat_of(d);
            mcnt[d]++;
          end
        end
      end
    end
    ecount++;
  endtask

  // One clock: check the outputs against the model, update the model, and
  // advance to the next falling edge.
  task automatic cycle();
    #1;
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        bit ev;
        ev = visible(d);
        chk($sformatf("L%0d rsp_valid", lat_of(d)), vld[d], ev);
        chk($sformatf("L%0d req_ready", lat_of(d)), rdy[d], (mcnt[d] < QD) && !flush);
        if (ev) begin
          mlast_d[d] = mdata[d][0];
          mlast_t[d] = mtag[d][0];
        end
        chk($sformatf("L%0d rsp_data", lat_of(d)), rdata[d], mlast_d[d]);
        chk($sformatf("L%0d rsp_tag", lat_of(d)), rtag[d], mlast_t[d]);
      end
    end
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    req_valid = 1'b0; we = 1'b0; flush = 1'b0; rst = 1'b0; be = '0;
  endtask

  task automatic idle(int n);
    set_idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drive_wr(logic [AW-1:0] a, logic [31:0] dv, logic [3:0] b);
    req_valid = 1'b1; we = 1'b1; addr = a; wdata = dv; be = b;
  endtask

  task automatic drive_rd(logic [AW-1:0] a, logic [TW-1:0] t);
    req_valid = 1'b1; we = 1'b0; addr = a; tag = t; be = '0;
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      mcnt[d] = 0; mlast_d[d] = '0; mlast_t[d] = '0;
    end
    rst = 1'b1; req_valid = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    be = '0; tag = '0; flush = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state.
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset L%0d valid", lat_of(d)), vld[d], 0);
      chk($sformatf("reset L%0d ready", lat_of(d)), rdy[d], 1);
      chk($sformatf("reset L%0d data", lat_of(d)), rdata[d], 0);
      chk($sformatf("reset L%0d tag", lat_of(d)), rtag[d], 0);
    end

    // Give every word a known value.
    for (int w = 0; w < NW; w++) begin
      drive_wr(AW'(w * 4), $urandom, 4'hF);
      cycle();
    end

    // Write, then read back in the following cycle.
    rsp_ready = 1'b1;
    drive_wr(8'h10, 32'hDEADBEEF, 4'hF); cycle();
    drive_rd(8'h10, 4'd3); cycle();
    set_idle();
    chk("raw L2 valid after accept edge", vld[1], 0);
    chk("raw L1 valid after accept edge", vld[0], 1);
    chk("raw L1 data", rdata[0], 32'hDEADBEEF);
    cycle();
    chk("raw L2 valid", vld[1], 1);
    chk("raw L2 data", rdata[1], 32'hDEADBEEF);
    chk("raw L2 tag", rtag[1], 3);
    idle(10);

    // Byte enables.
    drive_wr(8'h20, 32'h11223344, 4'hF); cycle();
    drive_wr(8'h20, 32'hAABBCCDD, 4'b0101); cycle();
    drive_rd(8'h20, 4'd5); cycle();
    set_idle(); cycle();
    chk("be merge valid", vld[1], 1);
    chk("be merge data", rdata[1], 32'h11BB33DD);
    chk("be merge tag", rtag[1], 5);
    idle(10);

    // Backpressure until full, then drain in order.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_rd(AW'(i * 4), TW'(i + 1));
      #1 chk($sformatf("full ready req%0d", i), rdy[1], (i < 4) ? 1 : 0);
      cycle();
    end
    idle(9);
    chk("full ready held low", rdy[1], 0);
    chk("full head tag", rtag[1], 1);
    rsp_ready = 1'b1;
    #1 chk("ready low during first pop", rdy[1], 0);
    cycle();
    chk("ready after first pop", rdy[1], 1);
    chk("order tag2", rtag[1], 2);
    cycle(); chk("order tag3", rtag[1], 3);
    cycle(); chk("order tag4", rtag[1], 4);
    cycle(); chk("drained valid", vld[1], 0);
    idle(10);

    // Flush with reads in flight, plus a write attempted under the flush.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rd(8'h20, TW'(7 + i)); cycle();
    end
    drive_wr(8'h10, 32'h0BADF00D, 4'hF);
    flush = 1'b1;
    #1 chk("ready low under flush", rdy[1], 0);
    cycle();
    set_idle();
    for (int d = 0; d < ND; d++)
      chk($sformatf("flush L%0d valid", lat_of(d)), vld[d], 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk($sformatf("no stale L8 %0d", i), vld[2], 0);
    end
    drive_rd(8'h10, 4'd2); cycle();
    set_idle(); cycle();
    chk("write blocked by flush", rdata[1], 32'hDEADBEEF);
    idle(10);

    // Reset with reads outstanding.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rd(8'h20, TW'(i + 1)); cycle();
    end
    set_idle(); rst = 1'b1; cycle(); rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst mid L%0d valid", lat_of(d)), vld[d], 0);
      chk($sformatf("rst mid L%0d ready", lat_of(d)), rdy[d], 1);
    end
    chk("rst mid data", rdata[1], 0);
    rsp_ready = 1'b1;
    drive_rd(8'h20, 4'd6); cycle();
    set_idle(); cycle();
    chk("mem kept over reset", rdata[1], 32'h11BB33DD);
    chk("mem kept tag", rtag[1], 6);
    idle(10);

    // Random traffic with flushes, resets and varying backpressure.
    for (int i = 0; i < 10000; i++) begin
      rst       = ($urandom_range(0, 999) == 0);
      flush     = ($urandom_range(0, 59) == 0);
      req_valid = ($urandom_range(0, 99) < 65);
      we        = ($urandom_range(0, 2) == 0);
      addr      = AW'($urandom);
      wdata     = $urandom;
      be        = 4'($urandom);
      tag       = TW'($urandom);
      rsp_ready = ($urandom_range(0, 99) < (((i / 1000) % 2 == 0) ? 35 : 85));
      cycle();
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
